mux_2x1_arbiter: RTL
====================

# mux_2x1_arbiter

Round-robin, packet-aware arbiter that shares one downstream valid/ready channel between two upstream requesters. It owns the 2:1 select of a data multiplexer (select 0 passes requester 0, select 1 passes requester 1) and sequences it so a packet is never interleaved. It sits directly in front of any single-consumer resource fed by two producers.

## Interface
- DATA_W, 8, width of each data bus
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- req0_valid  in  1  requester 0 has a beat
- req0_data  in  DATA_W  requester 0 beat data
- req0_last  in  1  beat is final beat of requester 0 packet
- req0_ready  out  1  requester 0 beat accepted this cycle
- req1_valid / req1_data / req1_last / req1_ready  same as above for requester 1
- out_valid  out  1  downstream beat valid
- out_data  out  DATA_W  downstream beat data
- out_last  out  1  downstream final beat of packet
- out_ready  in  1  downstream accepts beat
- sel  out  1  registered mux select; 0 = requester 0, 1 = requester 1
- busy  out  1  a grant is held (state not IDLE)

One clock; reset is synchronous and active-low.

## Operation
- States: IDLE, GRANT0, GRANT1. State, sel and round-robin pointer `prio` are registers.
- IDLE: out_valid=0, req0_ready=req1_ready=0. If exactly one reqN_valid=1, next state GRANTN. If both, grant the requester indicated by prio. Else stay.
- GRANTN: out_valid=reqN_valid, out_data=reqN_data, out_last=reqN_last, reqN_ready=out_ready; other requester's ready=0. sel=N.
- Transfer = out_valid & out_ready. On transfer with out_last=1 (end of packet): prio points to the other requester; if the other requester's valid=1 that cycle, next state is its GRANT (zero bubble); else IDLE.
- Transfer with out_last=0, or no transfer: stay in GRANTN. Grant is never removed mid-packet, regardless of the other requester.
- sel updates on the same edge as the state; in IDLE sel holds its last value. out_data always equals data of the requester selected by sel.
- Downstream signals are pure combinational functions of state and inputs; no data storage, no combinational path from out_ready to out_valid.
- Requester valid dropping mid-packet: grant held, out_valid follows it low.
- While rst_n=0, all readies and out_valid are forced 0 combinationally; no transfer occurs in a reset cycle.

## Timing
- Reset values: state IDLE, sel=0, prio=0 (requester 0 wins first tie), busy=0, out_valid=0, out_last=0, req0_ready=req1_ready=0.
- Arbitration latency from IDLE: request at cycle T → grant/out_valid at T+1, first transfer no earlier than T+1.
- Back-to-back packets from alternating requesters: 0 idle cycles between last beat of one and first beat of next.
- Same requester sending consecutive packets with the other idle: one IDLE cycle between packets.
- Throughput within packet: 1 beat/cycle when valid and ready are both high.
- Reset mid-packet: next cycle IDLE, sel=0, prio=0; partial packet abandoned, no further beats forwarded.

## Test plan
- Reset: hold rst_n=0 with both valids high for 3 cycles → all readies 0, out_valid 0, sel 0; release → GRANT0 one cycle later, sel=0.
- Single requester: req1 sends 3-beat packet 0xA1,0xA2,0xA3 (last on 3rd), out_ready=1 → sel=1, out_data 0xA1..0xA3 on consecutive cycles, out_last on 3rd, then IDLE.
- Contention: both send 2-beat packets continuously → packets alternate 0,1,0,1 with zero bubble; no beat of one interleaved inside the other's packet.
- Backpressure: out_ready toggling 1,0,1,0 during req0 packet while req1 valid → req1_ready stays 0, req0 beats delivered in order without loss or duplication, grant held until last.
- Same-source repeat: req0 sends two packets, req1 idle → one-cycle IDLE gap, busy=0 for that cycle.
- Reset mid-packet: assert rst_n=0 after beat 2 of a 4-beat req1 packet → out_valid 0 in reset cycle, then IDLE, sel=0, prio favors req0.

Source files
------------

// File: rtl/mux_2x1_arbiter.sv
// Packet-aware round-robin 2:1 arbiter driving the select of one valid/ready data mux.
// Grant appears one cycle after an IDLE request; downstream ready passes straight to the granted requester; no storage.
module mux_2x1_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   sel_q, sel_d;
  logic   prio_q, prio_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    prio_d     = prio_q;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0_valid && (!req1_valid || !prio_q)) begin
          state_d = GRANT0;
          sel_d   = 1'b0;
        end else if (req1_valid) begin
          state_d = GRANT1;
          sel_d   = 1'b1;
        end
      end
      GRANT0: begin
        out_valid  = req0_valid;
        out_last   = req0_last;
        req0_ready = out_ready;
        // End of packet: hand over without a bubble if the other side is waiting
        if (req0_valid && out_ready && req0_last) begin
          prio_d = 1'b1;
          if (req1_valid) begin
            state_d = GRANT1;
            sel_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GRANT1: begin
        out_valid  = req1_valid;
        out_last   = req1_last;
        req1_ready = out_ready;
        if (req1_valid && out_ready && req1_last) begin
          prio_d = 1'b0;
          if (req0_valid) begin
            state_d = GRANT0;
            sel_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A reset cycle must never complete a handshake
    if (!rst_n) begin
      out_valid  = 1'b0;
      out_last   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  assign out_data = sel_q ? req1_data : req0_data;
  assign sel      = sel_q;
  assign busy     = (state_q != IDLE);

endmodule
